// File: rtl/exc_pkg.sv
// Shared definitions for the ISR entry/exit sequencer: FSM state encoding,
// default vector numbers and the 2-bit accepted-event type code.
package exc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_REQ   = 2'd2,
        S_ISR   = 2'd3
    } state_t;

    localparam logic [7:0] VEC_GP_DEF  = 8'h0D;
    localparam logic [7:0] VEC_PF_DEF  = 8'h0E;
    localparam logic [7:0] VEC_INT_DEF = 8'h20;

    // Event type of the request accepted in IDLE; also selects a statistics counter.
    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_GP   = 2'd1;
    localparam logic [1:0] EXC_PF   = 2'd2;
    localparam logic [1:0] EXC_INT  = 2'd3;

endpackage

// File: rtl/exc_vec_sel.sv
// Combinational priority select: data-cache exception (protection over page
// fault) beats a pending external interrupt. Produces event type and vector.
module exc_vec_sel
    import exc_pkg::*;
#(
    parameter logic [7:0] VEC_GP  = VEC_GP_DEF,
    parameter logic [7:0] VEC_PF  = VEC_PF_DEF,
    parameter logic [7:0] VEC_INT = VEC_INT_DEF
) (
    input  logic       v_ro,
    input  logic       ro_stall,
    input  logic       dc_exp,
    input  logic       dc_prot_exp,
    input  logic       dc_page_fault,
    input  logic       ext_int,
    input  logic       isr,
    output logic [1:0] exc_type,
    output logic [7:0] vector
);

    logic take_exp;
    assign take_exp = v_ro & ~ro_stall & dc_exp & ~isr;

    always_comb begin
        exc_type = EXC_NONE;
        if (take_exp) begin
            if (dc_prot_exp)
                exc_type = EXC_GP;
            else if (dc_page_fault)
                exc_type = EXC_PF;
            else
                exc_type = EXC_PF;  // untyped data-cache exception is reported as a page fault
        end else if (ext_int) begin
            exc_type = EXC_INT;
        end
    end

    always_comb begin
        vector = 8'h00;
        case (exc_type)
            EXC_GP:  vector = VEC_GP;
            EXC_PF:  vector = VEC_PF;
            EXC_INT: vector = VEC_INT;
            default: vector = 8'h00;
        endcase
    end

endmodule

// File: rtl/exc_isr_seq.sv
// ISR entry/exit sequencer: capture EIP/vector, flush, drain, hand vector to
// fetch, hold isr until IRET. Optional event counters under EXC_STAT_EN.
module exc_isr_seq
    import exc_pkg::*;
#(
    parameter logic [7:0] VEC_GP  = VEC_GP_DEF,
    parameter logic [7:0] VEC_PF  = VEC_PF_DEF,
    parameter logic [7:0] VEC_INT = VEC_INT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        v_ro,
    input  logic        ro_stall,
    input  logic [31:0] ro_eip,
    input  logic        dc_exp,
    input  logic        dc_prot_exp,
    input  logic        dc_page_fault,
    input  logic        ext_int,
    input  logic        wb_drained,
    input  logic        isr_ack,
    input  logic        iret_retire,
    output logic        isr,
    output logic        exp_flush,
    output logic        isr_req,
    output logic [7:0]  isr_vector,
    output logic [31:0] saved_eip
`ifdef EXC_STAT_EN
    ,
    output logic [15:0] gp_cnt,
    output logic [15:0] pf_cnt,
    output logic [15:0] int_cnt
`endif
);

    state_t      state_q, state_d;
    logic [7:0]  vec_q, vec_d;
    logic [31:0] eip_q, eip_d;
    logic        flush_q;
    logic [1:0]  sel_type;
    logic [7:0]  sel_vec;
    logic        accept_idle;

    exc_vec_sel #(
        .VEC_GP  (VEC_GP),
        .VEC_PF  (VEC_PF),
        .VEC_INT (VEC_INT)
    ) u_vec_sel (
        .v_ro          (v_ro),
        .ro_stall      (ro_stall),
        .dc_exp        (dc_exp),
        .dc_prot_exp   (dc_prot_exp),
        .dc_page_fault (dc_page_fault),
        .ext_int       (ext_int),
        .isr           (isr),
        .exc_type      (sel_type),
        .vector        (sel_vec)
    );

    assign accept_idle = (state_q == S_IDLE) && (sel_type != EXC_NONE);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        eip_d   = eip_q;
        case (state_q)
            S_IDLE: begin
                if (accept_idle) begin
                    state_d = S_DRAIN;
                    vec_d   = sel_vec;
                    eip_d   = ro_eip;
                end
            end
            S_DRAIN: if (wb_drained)  state_d = S_REQ;
            S_REQ:   if (isr_ack)     state_d = S_ISR;
            S_ISR:   if (iret_retire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 8'h00;
            eip_q   <= 32'h0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            eip_q   <= eip_d;
            flush_q <= accept_idle;  // lands in the first DRAIN cycle only
        end
    end

    // isr covers the fetch handoff too, so the checker masks new exceptions then.
    assign isr        = (state_q == S_REQ) || (state_q == S_ISR);
    assign isr_req    = (state_q == S_REQ);
    assign exp_flush  = flush_q;
    assign isr_vector = vec_q;
    assign saved_eip  = eip_q;

`ifdef EXC_STAT_EN
    for (genvar gi = 1; gi <= 3; gi++) begin : g_cnt
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (accept_idle && (sel_type == 2'(gi)) && (cnt_q != 16'hFFFF))
                cnt_d = cnt_q + 16'd1;
        end

        always_ff @(posedge clk) begin
            if (rst)
                cnt_q <= 16'h0;
            else
                cnt_q <= cnt_d;
        end
    end

    assign gp_cnt  = g_cnt[1].cnt_q;
    assign pf_cnt  = g_cnt[2].cnt_q;
    assign int_cnt = g_cnt[3].cnt_q;
`endif

endmodule

// File: tb/tb_exc_isr_seq.sv
// Self-checking bench for exc_isr_seq: each entry's expected timeline is derived
// arithmetically from its drain/ack/handler lengths; build with EXC_STAT_EN for counters.
module tb_exc_isr_seq;

    logic        clk = 1'b0;
    logic        rst, v_ro, ro_stall, dc_exp, dc_prot_exp, dc_page_fault, ext_int;
    logic        wb_drained, isr_ack, iret_retire;
    logic [31:0] ro_eip;
    logic        isr, exp_flush, isr_req;
    logic [7:0]  isr_vector;
    logic [31:0] saved_eip;
`ifdef EXC_STAT_EN
    logic [15:0] gp_cnt, pf_cnt, int_cnt;
    int          m_gp, m_pf, m_int;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [7:0]  m_vec;
    logic [31:0] m_eip;

    exc_isr_seq dut (
        .clk           (clk),
        .rst           (rst),
        .v_ro          (v_ro),
        .ro_stall      (ro_stall),
        .ro_eip        (ro_eip),
        .dc_exp        (dc_exp),
        .dc_prot_exp   (dc_prot_exp),
        .dc_page_fault (dc_page_fault),
        .ext_int       (ext_int),
        .wb_drained    (wb_drained),
        .isr_ack       (isr_ack),
        .iret_retire   (iret_retire),
        .isr           (isr),
        .exp_flush     (exp_flush),
        .isr_req       (isr_req),
        .isr_vector    (isr_vector),
        .saved_eip     (saved_eip)
`ifdef EXC_STAT_EN
        ,
        .gp_cnt        (gp_cnt),
        .pf_cnt        (pf_cnt),
        .int_cnt       (int_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_vector(input bit take, input bit prot);
        if (take) return prot ? 8'h0D : 8'h0E;
        return 8'h20;
    endfunction

    task automatic quiet_inputs();
        v_ro = 1'b0; ro_stall = 1'b0; dc_exp = 1'b0; dc_prot_exp = 1'b0;
        dc_page_fault = 1'b0; ext_int = 1'b0; wb_drained = 1'b0;
        isr_ack = 1'b0; iret_retire = 1'b0; ro_eip = $urandom;
    endtask

    // One full entry starting from IDLE. d: cycles wb_drained held low in DRAIN,
    // a: REQ cycles before ack, l: handler cycles before IRET.
    task automatic run_entry(input string tag, input bit dc, input bit prot, input bit pf,
                             input bit ext, input bit hold_int, input logic [31:0] eip,
                             input int d, input int a, input int l);
        int t_req  = d + 2;
        int t_ack  = t_req + a;
        int t_iret = t_ack + 1 + l;
        v_ro = 1'b1; ro_stall = 1'b0; dc_exp = dc; dc_prot_exp = prot;
        dc_page_fault = pf; ext_int = ext; ro_eip = eip;
        wb_drained = 1'($urandom); isr_ack = 1'b0; iret_retire = 1'b0;
        m_vec = ref_vector(dc, prot);
        m_eip = eip;
`ifdef EXC_STAT_EN
        if (dc && prot)  m_gp  = (m_gp  < 16'hFFFF) ? m_gp  + 1 : m_gp;
        else if (dc)     m_pf  = (m_pf  < 16'hFFFF) ? m_pf  + 1 : m_pf;
        else             m_int = (m_int < 16'hFFFF) ? m_int + 1 : m_int;
`endif
        for (int k = 1; k <= t_iret + 1; k++) begin
            @(negedge clk);
            tests_run++;
            if (exp_flush !== (k == 1)) begin
                tests_failed++;
                $display("FAIL %s exp_flush k=%0d got %b want %b", tag, k, exp_flush, k == 1);
            end
            tests_run++;
            if (isr_req !== (k >= t_req && k <= t_ack)) begin
                tests_failed++;
                $display("FAIL %s isr_req k=%0d got %b want %b", tag, k, isr_req, k >= t_req && k <= t_ack);
            end
            tests_run++;
            if (isr !== (k >= t_req && k <= t_iret)) begin
                tests_failed++;
                $display("FAIL %s isr k=%0d got %b want %b", tag, k, isr, k >= t_req && k <= t_iret);
            end
            tests_run++;
            if (isr_vector !== m_vec || saved_eip !== m_eip) begin
                tests_failed++;
                $display("FAIL %s capture k=%0d got vec=%h eip=%h want vec=%h eip=%h",
                         tag, k, isr_vector, saved_eip, m_vec, m_eip);
            end
`ifdef EXC_STAT_EN
            if (k == 1) begin
                tests_run++;
                if (gp_cnt !== 16'(m_gp) || pf_cnt !== 16'(m_pf) || int_cnt !== 16'(m_int)) begin
                    tests_failed++;
                    $display("FAIL %s counters got gp=%0d pf=%0d int=%0d want gp=%0d pf=%0d int=%0d",
                             tag, gp_cnt, pf_cnt, int_cnt, m_gp, m_pf, m_int);
                end
            end
`endif
            // Drive for the next edge; noise on upstream inputs must be ignored while busy.
            v_ro = 1'($urandom); ro_stall = 1'($urandom); dc_exp = 1'($urandom);
            dc_prot_exp = 1'($urandom); dc_page_fault = 1'($urandom); ro_eip = $urandom;
            ext_int = hold_int | 1'($urandom);
            wb_drained = (k <= d) ? 1'b0 : ((k == d + 1) ? 1'b1 : 1'($urandom));
            isr_ack = (k == t_ack);
            iret_retire = (k <= t_ack) ? 1'($urandom) : (k == t_iret);
        end
        $display("[TB] %s entry vec=%h eip=%h drain=%0d ack=%0d body=%0d", tag, m_vec, m_eip, d, a, l);
    endtask

    task automatic apply_reset();
        quiet_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_vec = 8'h00; m_eip = 32'h0;
`ifdef EXC_STAT_EN
        m_gp = 0; m_pf = 0; m_int = 0;
`endif
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (isr !== 1'b0 || exp_flush !== 1'b0 || isr_req !== 1'b0 ||
            isr_vector !== 8'h00 || saved_eip !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset outputs got isr=%b flush=%b req=%b vec=%h eip=%h want all zero",
                     isr, exp_flush, isr_req, isr_vector, saved_eip);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_page_fault();
        run_entry("page_fault", 1, 0, 1, 0, 0, 32'h0000_1234, 0, 1, 2);
    endtask

    task automatic test_both_flags();
        run_entry("both_flags", 1, 1, 1, 0, 0, $urandom, 1, 0, 1);
    endtask

    task automatic test_int_vs_exc();
        run_entry("exc_over_int", 1, 0, 1, 1, 1, $urandom, 0, 0, 2);
        run_entry("pending_int", 0, 0, 0, 1, 0, $urandom, 0, 1, 1);
        run_entry("untyped_exc", 1, 0, 0, 1, 0, $urandom, 2, 0, 0);
    endtask

    task automatic test_drain_wait();
        run_entry("drain_wait", 1, 1, 0, 0, 0, $urandom, 5, 2, 3);
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 6; i++) begin
            quiet_inputs();
            v_ro = (i % 2 == 0);
            ro_stall = (i % 2 == 0);
            dc_exp = 1'b1; dc_prot_exp = 1'($urandom); dc_page_fault = 1'($urandom);
            iret_retire = 1'($urandom); isr_ack = 1'($urandom); wb_drained = 1'($urandom);
            @(negedge clk);
            tests_run++;
            if (exp_flush !== 1'b0 || isr !== 1'b0 || isr_req !== 1'b0 ||
                isr_vector !== m_vec || saved_eip !== m_eip) begin
                tests_failed++;
                $display("FAIL ignored i=%0d got flush=%b isr=%b req=%b vec=%h eip=%h want 0 0 0 %h %h",
                         i, exp_flush, isr, isr_req, isr_vector, saved_eip, m_vec, m_eip);
            end
        end
        quiet_inputs();
        $display("[TB] stalled/invalid exceptions ignored");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            bit dc = 1'($urandom);
            run_entry("random", dc, 1'($urandom), 1'($urandom), dc ? 1'($urandom) : 1'b1, 1'b0,
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_req();
        quiet_inputs();
        v_ro = 1'b1; dc_exp = 1'b1; dc_page_fault = 1'b1; ro_eip = $urandom;
        @(negedge clk);
        quiet_inputs();
        wb_drained = 1'b1;
        @(negedge clk);
        tests_run++;
        if (isr_req !== 1'b1 || isr !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_req setup got req=%b isr=%b want 1 1", isr_req, isr);
        end
        rst = 1'b1; ext_int = 1'b1; isr_ack = 1'b0;
        @(negedge clk);
        tests_run++;
        if (isr !== 1'b0 || isr_req !== 1'b0 || exp_flush !== 1'b0 ||
            isr_vector !== 8'h00 || saved_eip !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_in_req got isr=%b req=%b flush=%b vec=%h eip=%h want all zero",
                     isr, isr_req, exp_flush, isr_vector, saved_eip);
        end
        rst = 1'b0;
        quiet_inputs();
        m_vec = 8'h00; m_eip = 32'h0;
`ifdef EXC_STAT_EN
        m_gp = 0; m_pf = 0; m_int = 0;
`endif
        @(negedge clk);
        tests_run++;
        if (isr !== 1'b0 || isr_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_req idle got isr=%b req=%b want 0 0", isr, isr_req);
        end
        $display("[TB] reset during REQ aborts sequence");
    endtask

`ifdef EXC_STAT_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 3; i++)
            run_entry("stat_pf", 1, 0, 1, 0, 0, $urandom, 0, 0, 0);
        run_entry("stat_gp", 1, 1, 0, 0, 0, $urandom, 0, 0, 0);
        @(negedge clk);
        tests_run++;
        if (pf_cnt !== 16'd3 || gp_cnt !== 16'd1 || int_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats got pf=%0d gp=%0d int=%0d want 3 1 0", pf_cnt, gp_cnt, int_cnt);
        end
        force dut.g_cnt[2].cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.g_cnt[2].cnt_q;
        m_pf = 16'hFFFF;
        run_entry("stat_sat", 1, 0, 1, 0, 0, $urandom, 0, 0, 0);
        tests_run++;
        if (pf_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL stats_saturate got pf=%h want ffff", pf_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_page_fault();
        test_both_flags();
        test_int_vs_exc();
        test_drain_wait();
        test_ignored();
        test_random();
        test_reset_in_req();
`ifdef EXC_STAT_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
